// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit RISC core: opcodes, sequencer states and
// instruction field positions.
package risc_pkg;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLdi  = 4'h1;
  localparam logic [3:0] OpAdd  = 4'h2;
  localparam logic [3:0] OpSub  = 4'h3;
  localparam logic [3:0] OpAnd  = 4'h4;
  localparam logic [3:0] OpOr   = 4'h5;
  localparam logic [3:0] OpXor  = 4'h6;
  localparam logic [3:0] OpNot  = 4'h7;
  localparam logic [3:0] OpJmp  = 4'h8;
  localparam logic [3:0] OpJz   = 4'h9;
  localparam logic [3:0] OpHalt = 4'hF;

  localparam int unsigned OpcMsb = 15;
  localparam int unsigned OpcLsb = 12;
  localparam int unsigned RdMsb  = 11;
  localparam int unsigned RdLsb  = 8;
  localparam int unsigned RaMsb  = 7;
  localparam int unsigned RaLsb  = 4;
  localparam int unsigned RbMsb  = 3;
  localparam int unsigned RbLsb  = 0;
  localparam int unsigned ImmMsb = 7;
  localparam int unsigned ImmLsb = 0;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalt
  } state_e;

endpackage

// File: rtl/risc_decode.sv
// Opcode classifier: maps a 4-bit opcode onto one-hot instruction class flags.
module risc_decode
  import risc_pkg::*;
(
  input  logic [3:0] i_opcode,
  output logic       o_is_alu,
  output logic       o_is_ldi,
  output logic       o_is_jmp,
  output logic       o_is_jz,
  output logic       o_is_halt,
  output logic       o_is_nop,
  output logic       o_is_illegal
);

  always_comb begin
    o_is_alu     = 1'b0;
    o_is_ldi     = 1'b0;
    o_is_jmp     = 1'b0;
    o_is_jz      = 1'b0;
    o_is_halt    = 1'b0;
    o_is_nop     = 1'b0;
    o_is_illegal = 1'b0;
    unique case (i_opcode)
      OpNop:                                          o_is_nop     = 1'b1;
      OpLdi:                                          o_is_ldi     = 1'b1;
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNot:        o_is_alu     = 1'b1;
      OpJmp:                                          o_is_jmp     = 1'b1;
      OpJz:                                           o_is_jz      = 1'b1;
      OpHalt:                                         o_is_halt    = 1'b1;
      default:                                        o_is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/risc_sequencer.sv
// Fetch/decode/execute controller driving the ALU, register file and PC.
// Outputs are decoded from state and IR only; IMEM_DATA is consumed in DECODE.
module risc_sequencer
  import risc_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned AWIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic [AWIDTH-1:0] o_imem_addr,
  output logic              o_imem_rd,
  input  logic [15:0]       i_imem_data,
  output logic [3:0]        o_rf_ra,
  output logic [3:0]        o_rf_rb,
  output logic [3:0]        o_rf_wa,
  output logic              o_rf_we,
  output logic              o_rf_wsel,
  output logic [WIDTH-1:0]  o_imm,
  output logic              o_alu_en,
  output logic              o_alu_oe,
  output logic [3:0]        o_alu_opcode,
  input  logic              i_zf,
  output logic              o_halted,
  output logic              o_illegal
);

  state_e            r_state, w_state_next;
  logic [15:0]       r_ir, w_ir_next;
  logic [AWIDTH-1:0] r_pc, w_pc_next;
  logic              r_illegal, w_illegal_next;

  logic w_is_alu, w_is_ldi, w_is_jmp, w_is_jz, w_is_halt, w_is_nop, w_is_illegal;
  logic [AWIDTH-1:0] w_target;
  logic              w_ir_is_ldi;

  risc_decode u_decode (
    .i_opcode     (i_imem_data[OpcMsb:OpcLsb]),
    .o_is_alu     (w_is_alu),
    .o_is_ldi     (w_is_ldi),
    .o_is_jmp     (w_is_jmp),
    .o_is_jz      (w_is_jz),
    .o_is_halt    (w_is_halt),
    .o_is_nop     (w_is_nop),
    .o_is_illegal (w_is_illegal)
  );

  assign w_target = AWIDTH'(i_imem_data[ImmMsb:ImmLsb]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StFetch;
      r_ir      <= '0;
      r_pc      <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_ir      <= w_ir_next;
      r_pc      <= w_pc_next;
      r_illegal <= w_illegal_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_ir_next      = r_ir;
    w_pc_next      = r_pc;
    w_illegal_next = 1'b0;
    unique case (r_state)
      StFetch: w_state_next = StDecode;
      StDecode: begin
        w_ir_next = i_imem_data;
        w_pc_next = r_pc + AWIDTH'(1);
        if (w_is_alu) begin
          w_state_next = StExec;
        end else if (w_is_ldi) begin
          w_state_next = StWb;
        end else if (w_is_jmp) begin
          w_pc_next    = w_target;
          w_state_next = StFetch;
        end else if (w_is_jz) begin
          if (i_zf) w_pc_next = w_target;
          w_state_next = StFetch;
        end else if (w_is_halt) begin
          w_state_next = StHalt;
        end else begin
          // NOP and undefined opcodes both retire straight back to fetch
          w_illegal_next = w_is_illegal & ~w_is_nop;
          w_state_next   = StFetch;
        end
      end
      StExec:  w_state_next = StWb;
      StWb:    w_state_next = StFetch;
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StFetch;
    endcase
  end

  assign w_ir_is_ldi = (r_ir[OpcMsb:OpcLsb] == OpLdi);

  // Gate the read strobe with reset so no fetch is issued while held in reset
  assign o_imem_rd    = (r_state == StFetch) & i_rst_n;
  assign o_imem_addr  = r_pc;
  assign o_rf_ra      = r_ir[RaMsb:RaLsb];
  assign o_rf_rb      = r_ir[RbMsb:RbLsb];
  assign o_rf_wa      = r_ir[RdMsb:RdLsb];
  assign o_rf_we      = (r_state == StWb);
  assign o_rf_wsel    = o_rf_we & w_ir_is_ldi;
  assign o_imm        = o_rf_wsel ? WIDTH'(r_ir[ImmMsb:ImmLsb]) : '0;
  assign o_alu_en     = (r_state == StExec);
  assign o_alu_oe     = 1'b1;
  assign o_alu_opcode = o_alu_en ? r_ir[OpcMsb:OpcLsb] : 4'h0;
  assign o_halted     = (r_state == StHalt);
  assign o_illegal    = r_illegal;

endmodule
